// File: rtl/pcap_frame_pkg.sv
// Shared types and constants for the PCAP framing controller.
package pcap_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  localparam int CH_W = 32;

  localparam int FLG_DISARM  = 0;
  localparam int FLG_ENFALL  = 1;
  localparam int FLG_COUNT   = 2;
  localparam int FLG_NOFRAME = 3;
  localparam int FLG_COLLIDE = 4;

endpackage

// File: rtl/pcap_frame_chan.sv
// One capture channel: frame reference register, delta subtractor and
// raw/delta output mux. The reference register and subtractor only exist
// when PCAP_FRAMING_EN is defined; otherwise the channel is a wire.
module pcap_frame_chan
  import pcap_frame_pkg::*;
(
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            latch_i,
  input  logic            delta_en_i,
  input  logic [CH_W-1:0] val_i,
  output logic [CH_W-1:0] word_o
);

`ifdef PCAP_FRAMING_EN
  logic [CH_W-1:0] ref_q;

  // Reference snapshot on a frame edge; the sample in the same cycle still
  // sees the old value because word_o reads ref_q combinationally.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)      ref_q <= '0;
    else if (latch_i) ref_q <= val_i;
  end

  assign word_o = delta_en_i ? (val_i - ref_q) : val_i;
`else
  logic unused_ok;
  assign unused_ok = ^{clk_i, reset_i, latch_i, delta_en_i};
  assign word_o    = val_i;
`endif

endmodule

// File: rtl/pcap_frame_ctrl.sv
// PCAP framing controller: arm/enable/disarm FSM, capture and frame edge
// detection, per-channel sample words, saturating sample counter and
// sticky completion flags. Build option: PCAP_FRAMING_EN enables the
// frame-relative delta mode.
module pcap_frame_ctrl
  import pcap_frame_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int CNT_W = 32
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                arm_i,
  input  logic                disarm_i,
  input  logic                enable_i,
  input  logic                capture_i,
  input  logic                frame_i,
  input  logic                framing_en_i,
  input  logic [NCH-1:0]      framing_mask_i,
  input  logic [CNT_W-1:0]    max_samples_i,
  input  logic [NCH*CH_W-1:0] chan_val_i,
  output logic                smpl_valid_o,
  output logic [NCH*CH_W-1:0] smpl_data_o,
  output logic                armed_o,
  output logic                active_o,
  output logic                completed_o,
  output logic [7:0]          irq_flags_o,
  output logic [CNT_W-1:0]    smpl_count_o
);

  state_e                    state_q, state_d;
  logic                      cap_q, cap_d1_q, cap_edge;
  logic                      framing, frm_edge, frm_lat;
  logic                      frame_seen_q, frame_seen_d;
  logic                      smpl_valid_q, smpl_valid_d;
  logic [NCH-1:0][CH_W-1:0]  smpl_data_q, words;
  logic                      completed_q, completed_d;
  logic [7:0]                flags_q, flags_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                      emit, limit;

`ifdef PCAP_FRAMING_EN
  logic frm_q, frm_d1_q;

  // Frame level edge detector.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      frm_q    <= 1'b0;
      frm_d1_q <= 1'b0;
    end else begin
      frm_q    <= frame_i;
      frm_d1_q <= frm_q;
    end
  end

  assign framing  = framing_en_i;
  assign frm_edge = frm_q & ~frm_d1_q;
`else
  logic unused_ok;
  assign unused_ok = ^{frame_i, framing_en_i};
  assign framing   = 1'b0;
  assign frm_edge  = 1'b0;
`endif

  assign cap_edge = cap_q & ~cap_d1_q;
  assign frm_lat  = (state_q == ST_ACTIVE) & framing & frm_edge;

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    pcap_frame_chan u_chan (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .latch_i    (frm_lat),
      .delta_en_i (framing & framing_mask_i[n]),
      .val_i      (chan_val_i[n*CH_W +: CH_W]),
      .word_o     (words[n])
    );
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state, sample decision, counter and flag updates.
  always_comb begin
    state_d      = state_q;
    frame_seen_d = frame_seen_q;
    flags_d      = flags_q;
    cnt_d        = cnt_q;
    smpl_valid_d = 1'b0;
    completed_d  = 1'b0;
    emit         = 1'b0;
    limit        = 1'b0;
    cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (arm_i) begin
          state_d      = ST_ARMED;
          cnt_d        = '0;
          flags_d      = '0;
          frame_seen_d = 1'b0;
        end
      end
      ST_ARMED: begin
        if (disarm_i) begin
          state_d             = ST_IDLE;
          completed_d         = 1'b1;
          flags_d[FLG_DISARM] = 1'b1;
        end else if (enable_i) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (cap_edge) begin
          if (framing && !frame_seen_q) flags_d[FLG_NOFRAME] = 1'b1;
          else                          emit = 1'b1;
          if (framing && frm_edge)      flags_d[FLG_COLLIDE] = 1'b1;
        end
        if (framing && frm_edge) frame_seen_d = 1'b1;
        if (emit) begin
          smpl_valid_d = 1'b1;
          cnt_d        = cnt_inc;
          limit        = (max_samples_i != '0) && (cnt_inc >= max_samples_i);
        end
        // Only the highest-priority termination reason is recorded.
        if (disarm_i) begin
          state_d             = ST_IDLE;
          completed_d         = 1'b1;
          flags_d[FLG_DISARM] = 1'b1;
        end else if (limit) begin
          state_d            = ST_IDLE;
          completed_d        = 1'b1;
          flags_d[FLG_COUNT] = 1'b1;
        end else if (!enable_i) begin
          state_d             = ST_IDLE;
          completed_d         = 1'b1;
          flags_d[FLG_ENFALL] = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Edge detect, sample output and status registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cap_q        <= 1'b0;
      cap_d1_q     <= 1'b0;
      frame_seen_q <= 1'b0;
      smpl_valid_q <= 1'b0;
      smpl_data_q  <= '0;
      completed_q  <= 1'b0;
      flags_q      <= '0;
      cnt_q        <= '0;
    end else begin
      cap_q        <= capture_i;
      cap_d1_q     <= cap_q;
      frame_seen_q <= frame_seen_d;
      smpl_valid_q <= smpl_valid_d;
      if (smpl_valid_d) smpl_data_q <= words;
      completed_q  <= completed_d;
      flags_q      <= flags_d;
      cnt_q        <= cnt_d;
    end
  end

  assign smpl_valid_o = smpl_valid_q;
  assign smpl_data_o  = smpl_data_q;
  assign armed_o      = (state_q != ST_IDLE);
  assign active_o     = (state_q == ST_ACTIVE);
  assign completed_o  = completed_q;
  assign irq_flags_o  = flags_q;
  assign smpl_count_o = cnt_q;

endmodule

// File: doc/pcap_frame_ctrl.md
# pcap_frame_ctrl

Parametrised position-capture framing controller for the PCAP datapath. It arms on a register command, gates capture on `enable`, and emits one sample word per channel per capture. In framing mode, selected channels report the delta since the last frame edge. It also counts samples and raises completion status for the IRQ register. It is the multi-channel, count-limited successor to the fixed single-mode framing logic exercised by the `test.framing` bench.

## Interface
Parameters:
- NCH, 8, number of 32-bit capture channels (1..32)
- CNT_W, 32, width of sample counter and limit

Ports:
- clk_i  in  1  system clock (FCLK domain)
- reset_i  in  1  asynchronous, active-high reset
- arm_i  in  1  single-cycle arm command
- disarm_i  in  1  single-cycle disarm command
- enable_i  in  1  capture gate level (bit bus)
- capture_i  in  1  capture level; rising edge triggers a sample
- frame_i  in  1  frame level; rising edge latches reference values
- framing_en_i  in  1  framing mode enable
- framing_mask_i  in  NCH  1 = channel reports delta, 0 = raw value
- max_samples_i  in  CNT_W  sample limit; 0 = unlimited
- chan_val_i  in  NCH*32  channel values, channel n at [32n+31:32n]
- smpl_valid_o  out  1  one-cycle strobe, sample words valid
- smpl_data_o  out  NCH*32  captured words
- armed_o  out  1  high in ARMED or ACTIVE
- active_o  out  1  high in ACTIVE
- completed_o  out  1  one-cycle pulse on return to IDLE
- irq_flags_o  out  8  completion status, held until next arm
- smpl_count_o  out  CNT_W  samples emitted since arm

## Operation
- States: IDLE, ARMED, ACTIVE.
- IDLE → ARMED on arm_i. This clears smpl_count_o, irq_flags_o and the frame-seen flag. arm_i in ARMED or ACTIVE is ignored.
- ARMED → ACTIVE when enable_i = 1.
- ACTIVE → IDLE when enable_i falls (flag bit1).
- Any armed state → IDLE on disarm_i (flag bit0).
- ACTIVE → IDLE when smpl_count reaches a nonzero max_samples_i (flag bit2). The final sample is still emitted.
- Precedence in one cycle: disarm > count limit > enable fall. Only the highest-priority reason bit is set.
- Capture: a rising edge of capture_i in ACTIVE emits a sample. Edges in IDLE or ARMED are dropped.
- Framing (framing_en_i = 1):
  - A frame_i rising edge in ACTIVE latches every chan_val_i into a per-channel reference register and sets frame-seen.
  - Masked channels output chan_val − ref, modulo 2^32 (wraps, no saturation).
  - Unmasked channels output the raw value.
- Capture before the first frame edge since arm: the sample is suppressed, flag bit3 (frame error) is set, and the state does not change.
- Capture and frame edges in the same cycle: the sample uses the old reference, then the reference updates. Flag bit4 is set as a warning, and the sample is emitted if frame-seen was already set.
- Non-framing mode: all channels output raw values; frame_i is ignored.
- smpl_count saturates at all ones.
- Flag bits 7:5 are reserved and read 0.

## Timing
- Reset values: all outputs 0, state IDLE, references 0, edge-detect registers 0.
- Reset mid-capture discards any pending sample; no completed_o pulse.
- Edge detection registers the input, so an edge is detected in the cycle after the input first reads high at a clock edge.
- smpl_valid_o and smpl_data_o are registered, asserted on the clock after edge detection. Total latency: 2 clocks from capture_i high to smpl_valid_o.
- smpl_count_o updates in the same cycle as smpl_valid_o.
- Back-to-back captures are limited by the edge rate, minimum 2 clocks apart.
- completed_o and the state change occur together, 1 clock after the terminating event. With a count-limit stop, completed_o coincides with the final smpl_valid_o.
- armed_o and active_o are registered from state.

## Configuration
- `PCAP_FRAMING_EN` defined: framing logic, reference registers and subtractors are built.
- `PCAP_FRAMING_EN` undefined:
  - framing_en_i, framing_mask_i and frame_i are ignored, and no reference registers are generated.
  - All samples are raw.
  - Flag bits 3 and 4 are never set.

## Structure
- Package `pcap_frame_pkg`:
  - state enum
  - flag bit indices: FLG_DISARM = 0, FLG_ENFALL = 1, FLG_COUNT = 2, FLG_NOFRAME = 3, FLG_COLLIDE = 4
  - channel word width constant 32
- Sub-module `pcap_frame_chan`: one channel's reference register, subtractor and output mux. Instantiated NCH times in a generate loop.

## Test plan
- NCH = 4, non-framing: arm, enable = 1, capture edges with ch0 = 100 and ch0 = 250 → two samples, 2 clocks latency, smpl_count = 2.
- Framing with mask 4'b0001: frame at ch0 = 1000, capture at ch0 = 1300, ch1 = 7 → ch0 = 300, ch1 = 7. Frame at ch0 = 0xFFFFFFF0, capture at ch0 = 0x10 → ch0 = 0x20.
- max_samples = 3, five capture edges → exactly 3 samples, completed_o with the 3rd valid, flags = 0x04.
- Capture before any frame in framing mode → no sample, flag bit3 set. Capture and frame in the same cycle after a prior frame → sample uses old reference, flag bit4 set.
- disarm_i and enable fall in the same cycle → flags = 0x01. Repeat with arm_i during ACTIVE → arm_i ignored.
- reset_i asserted one clock after a capture edge → no smpl_valid_o, all outputs 0 next clock. Rebuild without `PCAP_FRAMING_EN` → framing stimulus yields raw values.
